// File: rtl/vga_frame_scanner.sv
// VGA raster generator with per-frame shadowed game geometry and pixel classification.
// All outputs are registered on the pixel tick, so they trail the counters by one tick.
module vga_frame_scanner #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BALL_W   = 12,
    parameter int BALL_H   = 17,
    parameter int SEGL_X0  = 0,
    parameter int SEGL_X1  = 4,
    parameter int SEGR_X0  = 636,
    parameter int SEGR_X1  = 639
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [9:0] p1_leftBound,
    input  logic [9:0] p1_rightBound,
    input  logic [9:0] p2_leftBound,
    input  logic [9:0] p2_rightBound,
    input  logic [8:0] p1_topBound,
    input  logic [8:0] p1_bottomBound,
    input  logic [8:0] p2_topBound,
    input  logic [8:0] p2_bottomBound,
    input  logic [8:0] segLeft_topBound,
    input  logic [8:0] segLeft_bottomBound,
    input  logic [8:0] segRight_topBound,
    input  logic [8:0] segRight_bottomBound,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_class,
    output logic       screen_end,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        CLS_BG       = 3'd0,
        CLS_P1       = 3'd1,
        CLS_P2       = 3'd2,
        CLS_BALL     = 3'd3,
        CLS_SEGLEFT  = 3'd4,
        CLS_SEGRIGHT = 3'd5
    } pixClass_t;

    logic [DIV_W-1:0] divCnt;
    logic             tick;
    logic [9:0]       hCnt;
    logic [9:0]       vCnt;
    logic             hWrap;
    logic             vWrap;
    logic             loadPending;

    logic [9:0] shBallX, shP1Left, shP1Right, shP2Left, shP2Right;
    logic [8:0] shBallY, shP1Top, shP1Bottom, shP2Top, shP2Bottom;
    logic [8:0] shSegLTop, shSegLBottom, shSegRTop, shSegRBottom;

    logic       hsActive, vsActive, vis, blank;
    logic       p1Hit, p2Hit, ballHit, segLeftHit, segRightHit;
    logic [10:0] ballEndX, ballEndY;
    pixClass_t  classNext;

    assign tick  = (divCnt == DIV_W'(CLK_DIV - 1));
    assign hWrap = (hCnt == 10'(H_TOTAL - 1));
    assign vWrap = (vCnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            divCnt <= '0;
        end else begin
            divCnt <= tick ? '0 : divCnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (tick) begin
            if (hWrap) begin
                hCnt <= '0;
                vCnt <= vWrap ? 10'd0 : vCnt + 10'd1;
            end else begin
                hCnt <= hCnt + 10'd1;
            end
        end
    end

    // Geometry is sampled once per frame on the last line so a frame never shows a half-moved object.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loadPending  <= 1'b1;
            shBallX      <= '0;
            shBallY      <= '0;
            shP1Left     <= '0;
            shP1Right    <= '0;
            shP1Top      <= '0;
            shP1Bottom   <= '0;
            shP2Left     <= '0;
            shP2Right    <= '0;
            shP2Top      <= '0;
            shP2Bottom   <= '0;
            shSegLTop    <= '0;
            shSegLBottom <= '0;
            shSegRTop    <= '0;
            shSegRBottom <= '0;
        end else if (tick && (loadPending || (hCnt == 10'd0 && vWrap))) begin
            loadPending  <= 1'b0;
            shBallX      <= ball_x;
            shBallY      <= ball_y;
            shP1Left     <= p1_leftBound;
            shP1Right    <= p1_rightBound;
            shP1Top      <= p1_topBound;
            shP1Bottom   <= p1_bottomBound;
            shP2Left     <= p2_leftBound;
            shP2Right    <= p2_rightBound;
            shP2Top      <= p2_topBound;
            shP2Bottom   <= p2_bottomBound;
            shSegLTop    <= segLeft_topBound;
            shSegLBottom <= segLeft_bottomBound;
            shSegRTop    <= segRight_topBound;
            shSegRBottom <= segRight_bottomBound;
        end
    end

    assign hsActive = (hCnt >= 10'(HS_START)) && (hCnt <= 10'(HS_END));
    assign vsActive = (vCnt >= 10'(VS_START)) && (vCnt <= 10'(VS_END));
    assign vis      = (hCnt < 10'(H_ACTIVE)) && (vCnt < 10'(V_ACTIVE));
    assign blank    = (vCnt >= 10'(V_ACTIVE));

    // Ball extents are one bit wider so a ball near the right/bottom edge never wraps to zero.
    assign ballEndX = {1'b0, shBallX} + 11'(BALL_W);
    assign ballEndY = {2'b00, shBallY} + 11'(BALL_H);

    always_comb begin
        p1Hit = (hCnt >= shP1Left) && (hCnt <= shP1Right)
             && (vCnt >= {1'b0, shP1Top}) && (vCnt <= {1'b0, shP1Bottom});
        p2Hit = (hCnt >= shP2Left) && (hCnt <= shP2Right)
             && (vCnt >= {1'b0, shP2Top}) && (vCnt <= {1'b0, shP2Bottom});
        ballHit = (hCnt >= shBallX) && ({1'b0, hCnt} < ballEndX)
               && (vCnt >= {1'b0, shBallY}) && ({1'b0, vCnt} < ballEndY);
        segLeftHit = ((hCnt - 10'(SEGL_X0)) <= 10'(SEGL_X1 - SEGL_X0))
                  && (vCnt >= {1'b0, shSegLTop}) && (vCnt <= {1'b0, shSegLBottom});
        segRightHit = ((hCnt - 10'(SEGR_X0)) <= 10'(SEGR_X1 - SEGR_X0))
                   && (vCnt >= {1'b0, shSegRTop}) && (vCnt <= {1'b0, shSegRBottom});
    end

    always_comb begin
        classNext = CLS_BG;
        if (vis) begin
            if (ballHit)          classNext = CLS_BALL;
            else if (p1Hit)       classNext = CLS_P1;
            else if (p2Hit)       classNext = CLS_P2;
            else if (segLeftHit)  classNext = CLS_SEGLEFT;
            else if (segRightHit) classNext = CLS_SEGRIGHT;
        end
    end

    // frame_start is written every clock so it drops after the single clock that follows the wrap tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_class   <= '0;
            screen_end  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && hWrap && vWrap;
            if (tick) begin
                hsync      <= ~hsActive;
                vsync      <= ~vsActive;
                video_on   <= vis;
                pix_x      <= hCnt;
                pix_y      <= vCnt;
                pix_class  <= classNext;
                screen_end <= blank;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner on a reduced 56x37 raster (CLK_DIV=2) so whole frames
// fit in a short run: line = 112 clocks, frame = 4144 clocks, 7 blanking lines, 4x5 ball.
module tb_vga_frame_scanner;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 40;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 6;
    localparam int V_ACTIVE = 30;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int LINE_CLKS  = 112;
    localparam int FRAME_CLKS = 4144;
    localparam int WAIT_LIMIT = 2 * FRAME_CLKS + 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [9:0] p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound;
    logic [8:0] p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound;
    logic [8:0] segLeft_topBound, segLeft_bottomBound, segRight_topBound, segRight_bottomBound;
    logic       hsync, vsync, video_on, screen_end, frame_start;
    logic [9:0] pix_x, pix_y;
    logic [2:0] pix_class;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vga_frame_scanner #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BALL_W(4), .BALL_H(5), .SEGL_X0(0), .SEGL_X1(2), .SEGR_X0(37), .SEGR_X1(39)
    ) dut (
        .clock(clock), .reset(reset),
        .ball_x(ball_x), .ball_y(ball_y),
        .p1_leftBound(p1_leftBound), .p1_rightBound(p1_rightBound),
        .p2_leftBound(p2_leftBound), .p2_rightBound(p2_rightBound),
        .p1_topBound(p1_topBound), .p1_bottomBound(p1_bottomBound),
        .p2_topBound(p2_topBound), .p2_bottomBound(p2_bottomBound),
        .segLeft_topBound(segLeft_topBound), .segLeft_bottomBound(segLeft_bottomBound),
        .segRight_topBound(segRight_topBound), .segRight_bottomBound(segRight_bottomBound),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pix_x(pix_x), .pix_y(pix_y), .pix_class(pix_class),
        .screen_end(screen_end), .frame_start(frame_start)
    );

    // Every box degenerate and the ball parked off-screen: nothing classifies.
    task automatic applyStimulus();
        ball_x = 10'd1000;  ball_y = 9'd500;
        p1_leftBound = 10'd1; p1_rightBound = 10'd0; p1_topBound = 9'd1; p1_bottomBound = 9'd0;
        p2_leftBound = 10'd1; p2_rightBound = 10'd0; p2_topBound = 9'd1; p2_bottomBound = 9'd0;
        segLeft_topBound = 9'd1;  segLeft_bottomBound = 9'd0;
        segRight_topBound = 9'd1; segRight_bottomBound = 9'd0;
    endtask

    task automatic waitFrame();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (frame_start !== 1'b1 && n < WAIT_LIMIT);
        if (frame_start !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_start_timeout: waited %0d clocks, required a pulse", n);
        end
    endtask

    task automatic waitPixel(input int x, input int y, output logic [2:0] cls);
        int  n = 0;
        bit  found = 0;
        cls = 3'bxxx;
        while (!found && n < WAIT_LIMIT) begin
            @(negedge clock);
            n++;
            if (pix_x == 10'(x) && pix_y == 10'(y)) begin
                found = 1;
                cls = pix_class;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL pixel_timeout: (%0d,%0d) never appeared", x, y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus();
        repeat (4) @(negedge clock);
        checks++; if (hsync !== 1'b1)      begin errors++; $display("[TB] FAIL reset_hsync: got %b, expected 1", hsync); end
        checks++; if (vsync !== 1'b1)      begin errors++; $display("[TB] FAIL reset_vsync: got %b, expected 1", vsync); end
        checks++; if (video_on !== 1'b0)   begin errors++; $display("[TB] FAIL reset_video_on: got %b, expected 0", video_on); end
        checks++; if (pix_x !== 10'd0)     begin errors++; $display("[TB] FAIL reset_pix_x: got %0d, expected 0", pix_x); end
        checks++; if (pix_y !== 10'd0)     begin errors++; $display("[TB] FAIL reset_pix_y: got %0d, expected 0", pix_y); end
        checks++; if (pix_class !== 3'd0)  begin errors++; $display("[TB] FAIL reset_pix_class: got %0d, expected 0", pix_class); end
        checks++; if (screen_end !== 1'b0) begin errors++; $display("[TB] FAIL reset_screen_end: got %b, expected 0", screen_end); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b, expected 0", frame_start); end
        reset = 1'b0;
    endtask

    // One full frame window, frame_start to frame_start, covers exactly one period of every signal.
    task automatic test_timing();
        int n = 0, hsLow = 0, vsLow = 0, vidOn = 0, seHigh = 0, fsHigh = 0, vidBad = 0;
        int hsFall1 = -1, hsFall2 = -1, seRiseX = -1, seRiseY = -1, seFallY = -1;
        logic prevHs, prevSe;
        waitFrame();
        prevHs = hsync;
        prevSe = screen_end;
        do begin
            @(negedge clock);
            n++;
            if (hsync == 1'b0) hsLow++;
            if (vsync == 1'b0) vsLow++;
            if (video_on == 1'b1) vidOn++;
            if (screen_end == 1'b1) seHigh++;
            if (frame_start == 1'b1) fsHigh++;
            if (prevHs && !hsync) begin
                if (hsFall1 < 0) hsFall1 = n;
                else if (hsFall2 < 0) hsFall2 = n;
            end
            if (!prevSe && screen_end) begin seRiseX = int'(pix_x); seRiseY = int'(pix_y); end
            if (prevSe && !screen_end) seFallY = int'(pix_y);
            if (video_on !== (pix_x < 10'(H_ACTIVE) && pix_y < 10'(V_ACTIVE))) vidBad++;
            prevHs = hsync;
            prevSe = screen_end;
        end while (frame_start !== 1'b1 && n < WAIT_LIMIT);
        checks++; if (n != FRAME_CLKS)             begin errors++; $display("[TB] FAIL frame_period: got %0d, expected %0d", n, FRAME_CLKS); end
        checks++; if (fsHigh != 1)                 begin errors++; $display("[TB] FAIL frame_start_width: got %0d, expected 1", fsHigh); end
        checks++; if (hsFall2 - hsFall1 != LINE_CLKS) begin errors++; $display("[TB] FAIL hsync_period: got %0d, expected %0d", hsFall2 - hsFall1, LINE_CLKS); end
        checks++; if (hsLow != 37 * 12)            begin errors++; $display("[TB] FAIL hsync_low: got %0d, expected %0d", hsLow, 37 * 12); end
        checks++; if (vsLow != 2 * LINE_CLKS)      begin errors++; $display("[TB] FAIL vsync_low: got %0d, expected %0d", vsLow, 2 * LINE_CLKS); end
        checks++; if (vidOn != 30 * 40 * 2)        begin errors++; $display("[TB] FAIL video_on_count: got %0d, expected %0d", vidOn, 2400); end
        checks++; if (vidBad != 0)                 begin errors++; $display("[TB] FAIL video_on_region: got %0d bad clocks, expected 0", vidBad); end
        checks++; if (seHigh != 7 * LINE_CLKS)     begin errors++; $display("[TB] FAIL screen_end_high: got %0d, expected %0d", seHigh, 7 * LINE_CLKS); end
        checks++; if (seRiseX != 0 || seRiseY != 30) begin errors++; $display("[TB] FAIL screen_end_rise: got (%0d,%0d), expected (0,30)", seRiseX, seRiseY); end
        checks++; if (seFallY != 0)                begin errors++; $display("[TB] FAIL screen_end_fall: got y=%0d, expected 0", seFallY); end
    endtask

    task automatic test_paddle();
        int pts [6][3];
        logic [2:0] cls;
        pts = '{'{4,12,0}, '{7,12,1}, '{11,12,0}, '{9,14,1}, '{10,15,1}, '{12,18,2}};
        p1_leftBound = 10'd5;  p1_rightBound = 10'd10; p1_topBound = 9'd8;  p1_bottomBound = 9'd15;
        p2_leftBound = 10'd8;  p2_rightBound = 10'd15; p2_topBound = 9'd14; p2_bottomBound = 9'd20;
        waitFrame();
        for (int i = 0; i < 6; i++) begin
            waitPixel(pts[i][0], pts[i][1], cls);
            checks++;
            if (cls !== 3'(pts[i][2])) begin
                errors++;
                $display("[TB] FAIL paddle(%0d,%0d): got %0d, expected %0d", pts[i][0], pts[i][1], cls, pts[i][2]);
            end
        end
    endtask

    task automatic test_ball();
        int pts [5][3];
        logic [2:0] cls;
        pts = '{'{8,11,1}, '{9,11,3}, '{13,11,0}, '{12,15,3}, '{11,16,2}};
        ball_x = 10'd9;
        ball_y = 9'd11;
        waitFrame();
        for (int i = 0; i < 5; i++) begin
            waitPixel(pts[i][0], pts[i][1], cls);
            checks++;
            if (cls !== 3'(pts[i][2])) begin
                errors++;
                $display("[TB] FAIL ball(%0d,%0d): got %0d, expected %0d", pts[i][0], pts[i][1], cls, pts[i][2]);
            end
        end
    endtask

    task automatic test_segments();
        int pts [7][3];
        logic [2:0] cls;
        pts = '{'{36,12,0}, '{38,12,5}, '{1,16,4}, '{3,16,0}, '{39,20,5}, '{39,25,3}, '{40,25,0}};
        segLeft_topBound = 9'd12;  segLeft_bottomBound = 9'd20;
        segRight_topBound = 9'd12; segRight_bottomBound = 9'd20;
        ball_x = 10'd38;
        ball_y = 9'd25;
        waitFrame();
        for (int i = 0; i < 7; i++) begin
            waitPixel(pts[i][0], pts[i][1], cls);
            checks++;
            if (cls !== 3'(pts[i][2])) begin
                errors++;
                $display("[TB] FAIL segment(%0d,%0d): got %0d, expected %0d", pts[i][0], pts[i][1], cls, pts[i][2]);
            end
        end
    endtask

    task automatic test_shadow();
        logic [2:0] cls;
        p1_leftBound = 10'd25; p1_rightBound = 10'd30; p1_topBound = 9'd20; p1_bottomBound = 9'd25;
        waitFrame();
        waitPixel(0, 10, cls);
        p1_leftBound = 10'd30; p1_rightBound = 10'd35; p1_topBound = 9'd2;  p1_bottomBound = 9'd6;
        waitPixel(27, 22, cls);
        checks++; if (cls !== 3'd1) begin errors++; $display("[TB] FAIL shadow_hold(27,22): got %0d, expected 1", cls); end
        waitFrame();
        waitPixel(32, 4, cls);
        checks++; if (cls !== 3'd1) begin errors++; $display("[TB] FAIL shadow_new(32,4): got %0d, expected 1", cls); end
        waitPixel(27, 22, cls);
        checks++; if (cls !== 3'd0) begin errors++; $display("[TB] FAIL shadow_old_gone(27,22): got %0d, expected 0", cls); end
    endtask

    task automatic test_reset_midline();
        int n = 0;
        while (hsync !== 1'b0 && n < 2 * LINE_CLKS) begin
            @(negedge clock);
            n++;
        end
        checks++; if (hsync !== 1'b0) begin errors++; $display("[TB] FAIL hsync_low_seen: got %b, expected 0", hsync); end
        reset = 1'b1;
        #1;
        checks++; if (hsync !== 1'b1)  begin errors++; $display("[TB] FAIL async_reset_hsync: got %b, expected 1", hsync); end
        checks++; if (pix_x !== 10'd0) begin errors++; $display("[TB] FAIL async_reset_pix_x: got %0d, expected 0", pix_x); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (frame_start !== 1'b1 && n < WAIT_LIMIT);
        checks++; if (n != FRAME_CLKS) begin errors++; $display("[TB] FAIL first_frame_after_reset: got %0d, expected %0d", n, FRAME_CLKS); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_paddle();
        test_ball();
        test_segments();
        test_shadow();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_scanner.md
Name: vga_frame_scanner

Overview:
- Generates 640x480@60 VGA raster timing from the system clock.
- Produces the `screen_end` level consumed by the regfile's posEdgeScreenEnd input, so the game logic advances once per frame.
- Reads back the game-object geometry the regfile exports (paddle bounds, ball position, score segments) and classifies each pixel for the colour stage.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (2 gives 25 MHz from 50 MHz).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- BALL_W, 12, ball width in pixels.
- BALL_H, 17, ball height in pixels.
- SEGL_X0 / SEGL_X1, 0 / 4, left segment x span, inclusive.
- SEGR_X0 / SEGR_X1, 636 / 639, right segment x span, inclusive.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ball_x  in  10  ball left edge
- ball_y  in  9  ball top edge
- p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound  in  10 each  paddle x bounds, inclusive
- p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound  in  9 each  paddle y bounds, inclusive
- segLeft_topBound, segLeft_bottomBound, segRight_topBound, segRight_bottomBound  in  9 each  segment y bounds, inclusive
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high for visible pixels
- pix_x  out  10  current pixel x
- pix_y  out  10  current pixel y
- pix_class  out  3  pixel class: 0 background, 1 p1, 2 p2, 3 ball, 4 segLeft, 5 segRight
- screen_end  out  1  high during vertical blanking
- frame_start  out  1  one-clock pulse at the start of each frame

Behaviour:
- Interface: one clock, `clock`; reset `reset` is asynchronous and active-high.
- Reset values:
  - Tick divider, h_cnt and v_cnt = 0.
  - hsync = 1, vsync = 1.
  - video_on, pix_x, pix_y, pix_class, screen_end, frame_start = 0.
  - All geometry shadow registers = 0; load_pending = 1.
- Reset mid-operation: outputs take reset values immediately, without waiting for a clock edge. Counting restarts at (0,0) after deassertion.
- Tick: a divider counts 0..CLK_DIV-1. `tick` is high in the clock where divider = CLK_DIV-1. All counters and output registers advance only on tick.
- Horizontal counter: h_cnt counts 0..H_TOTAL-1, H_TOTAL = 800.
- Vertical counter: v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, V_TOTAL = 525. Both wrap to 0.
- Decode, from counter values before increment:
  - hs_n low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vs_n low for v in [490,491].
  - vis = h<640 && v<480.
  - blank = v>=480.
- Output stage: registers decode, h, v and class on each tick. All outputs therefore lag the counters by exactly one pixel tick and stay mutually aligned. Outputs hold between ticks.
- screen_end = registered blank. It rises at the first tick of line 480 and falls at the first tick of line 0.
- frame_start: high for exactly one clock, on the tick where the counters wrap from (799,524) to (0,0).
- Geometry shadows: all inputs are copied into shadow registers on the tick where (h,v) = (0, V_TOTAL-1), and on the first tick after reset (this clears load_pending). Input changes at any other time have no visible effect until the next load. This gives tear-free frames.
- Classification, combinational on the shadows, only when vis (else 0):
  - Paddles: left<=x<=right && top<=y<=bottom, all inclusive.
  - Ball: ball_x <= x < ball_x+BALL_W && ball_y <= y < ball_y+BALL_H. Sums are computed 11 bits wide with no wrap.
  - Segments: x in the SEGx span && top<=y<=bottom.
  - The 9-bit y values are zero-extended to 10 bits before compare.
  - Priority: ball > p1 > p2 > segLeft > segRight.
- Degenerate box (left>right or top>bottom): matches nothing.

Test Plan:
- Timing: reset, run 2 frames at CLK_DIV=2 -> hsync period 1600 clocks with a 192-clock low pulse; vsync low 3200 clocks; frame_start pulses spaced exactly 840000 clocks apart; video_on high for 640 ticks per line on lines 0..479 only.
- screen_end: rises when pix_y = 480, pix_x = 0; falls when pix_y = 0; 480 lines high-to-low... exactly 45 lines high per frame.
- Paddle hit: p1 bounds x 55..105, y 207..273, loaded before a frame -> (80,240) = 1, (105,273) = 1, (54,240) = 0, (106,240) = 0.
- Ball and priority: ball (320,240) -> (331,256) = 3, (332,240) = 0, (320,257) = 0; ball (60,210) overlapping p1 -> (60,210) = 3.
- Segments: segLeft y 200..280 -> (2,240) = 4, (5,240) = 0; segRight same bounds -> (637,200) = 5.
- Shadow and reset: change p1 bounds at pix_y = 100 -> class unchanged until the next frame. Assert reset mid-line -> hsync = 1 and pix_x = 0 in the same time step; after release, the first frame_start comes 840000 clocks later.
